// File: rtl/rx_depacketing_hdr.sv
// rx_depacketing_hdr: strips a fixed-length, beat-aligned header from each
// router frame. It decodes dst/src from header beat 0, drops frames not
// addressed to this node, and forwards payload beats through a registered
// two-entry FIFO. Saturating drop and runt counters are kept.
module rx_depacketing_hdr #(
    parameter int DATA_W    = 128,
    parameter int KEEP_W    = DATA_W / 32,
    parameter int HDR_BEATS = 1,
    parameter bit PASS_ALL  = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       io_local_id,

    input  logic              io_axi_str_from_router_valid,
    output logic              io_axi_str_from_router_ready,
    input  logic [DATA_W-1:0] io_axi_str_from_router_bits_tdata,
    input  logic [KEEP_W-1:0] io_axi_str_from_router_bits_tkeep,
    input  logic              io_axi_str_from_router_bits_tlast,

    output logic              io_axis_str_to_trans_valid,
    input  logic              io_axis_str_to_trans_ready,
    output logic [DATA_W-1:0] io_axis_str_to_trans_bits_tdata,
    output logic [KEEP_W-1:0] io_axis_str_to_trans_bits_tkeep,
    output logic              io_axis_str_to_trans_bits_tlast,

    output logic              io_hdr_valid,
    output logic [15:0]       io_hdr_dst,
    output logic [15:0]       io_hdr_src,
    output logic [CNT_W-1:0]  io_drop_cnt,
    output logic [CNT_W-1:0]  io_runt_cnt
);

    localparam int BC_W = $clog2(HDR_BEATS + 1);
    localparam logic [BC_W-1:0] LAST_HDR = BC_W'(HDR_BEATS - 1);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PASS = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BC_W-1:0]   r_beat_cnt;
    logic              r_in_ready;
    logic [15:0]       r_dst_hold;
    logic [15:0]       r_src_hold;
    logic              r_hdr_valid;
    logic [15:0]       r_hdr_dst;
    logic [15:0]       r_hdr_src;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [CNT_W-1:0]  r_runt_cnt;

    logic [DATA_W-1:0] r_mem_data [0:1];
    logic [KEEP_W-1:0] r_mem_keep [0:1];
    logic              r_mem_last [0:1];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;

    logic              w_in_acc;
    logic              w_last_hdr;
    logic [15:0]       w_dst_cur;
    logic [15:0]       w_src_cur;
    logic              w_match;
    logic              w_hdr_end;
    logic              w_runt;
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_occ_nxt;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_in_acc   = io_axi_str_from_router_valid && r_in_ready;
    assign w_last_hdr = (r_beat_cnt == LAST_HDR);
    // With a single header beat the holding registers are not yet loaded
    // when the decision is made, so take the fields straight from the bus.
    assign w_dst_cur  = (r_beat_cnt == '0) ? io_axi_str_from_router_bits_tdata[15:0]
                                           : r_dst_hold;
    assign w_src_cur  = (r_beat_cnt == '0) ? io_axi_str_from_router_bits_tdata[31:16]
                                           : r_src_hold;
    assign w_match    = PASS_ALL || (w_dst_cur == io_local_id);
    assign w_pop      = (r_occ != 2'd0) && io_axis_str_to_trans_ready;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_HDR;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode: header end chooses pass/drop, tlast ends a frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HDR: begin
                if (w_runt)         w_state_nxt = S_HDR;
                else if (w_hdr_end) w_state_nxt = w_match ? S_PASS : S_DROP;
            end
            S_PASS, S_DROP: begin
                if (w_in_acc && io_axi_str_from_router_bits_tlast) w_state_nxt = S_HDR;
            end
            default: w_state_nxt = S_HDR;
        endcase
    end

    // Per-state strobes: runt / header completion in S_HDR, FIFO push in S_PASS.
    always_comb begin
        w_push    = 1'b0;
        w_hdr_end = 1'b0;
        w_runt    = 1'b0;
        case (r_state)
            S_HDR: begin
                w_runt    = w_in_acc && io_axi_str_from_router_bits_tlast;
                w_hdr_end = w_in_acc && !io_axi_str_from_router_bits_tlast && w_last_hdr;
            end
            S_PASS:  w_push = w_in_acc;
            default: ;
        endcase
    end

    // Next FIFO occupancy; push and pop together leave it unchanged.
    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_nxt = r_occ + 2'd1;
            2'b01:   w_occ_nxt = r_occ - 2'd1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Registered input ready, header beat counter, header outputs and statistics.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_in_ready  <= 1'b0;
            r_beat_cnt  <= '0;
            r_hdr_valid <= 1'b0;
            r_hdr_dst   <= '0;
            r_hdr_src   <= '0;
            r_drop_cnt  <= '0;
            r_runt_cnt  <= '0;
        end else begin
            // Ready for next cycle from next-cycle occupancy, so a push can
            // never find the FIFO full and downstream ready never reaches
            // the input ready combinationally.
            r_in_ready  <= (w_state_nxt != S_PASS) || (w_occ_nxt != 2'd2);
            r_hdr_valid <= w_hdr_end && w_match;
            if (w_hdr_end && w_match) begin
                r_hdr_dst <= w_dst_cur;
                r_hdr_src <= w_src_cur;
            end
            if (w_hdr_end && !w_match) r_drop_cnt <= sat_inc(r_drop_cnt);
            if (w_runt)                r_runt_cnt <= sat_inc(r_runt_cnt);
            if (r_state == S_HDR && w_in_acc) begin
                if (io_axi_str_from_router_bits_tlast || w_last_hdr) r_beat_cnt <= '0;
                else                                                  r_beat_cnt <= r_beat_cnt + BC_W'(1);
            end
        end
    end

    // Header field capture from beat 0 (data path, no reset needed).
    always_ff @(posedge clock) begin
        if (r_state == S_HDR && w_in_acc && r_beat_cnt == '0) begin
            r_dst_hold <= io_axi_str_from_router_bits_tdata[15:0];
            r_src_hold <= io_axi_str_from_router_bits_tdata[31:16];
        end
    end

    // FIFO storage write (data path, no reset needed).
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= io_axi_str_from_router_bits_tdata;
            r_mem_keep[r_wr_ptr] <= io_axi_str_from_router_bits_tkeep;
            r_mem_last[r_wr_ptr] <= io_axi_str_from_router_bits_tlast;
        end
    end

    // FIFO pointers and occupancy; reset flushes any buffered beats.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_occ <= w_occ_nxt;
        end
    end

    assign io_axi_str_from_router_ready    = r_in_ready;
    assign io_axis_str_to_trans_valid      = (r_occ != 2'd0);
    assign io_axis_str_to_trans_bits_tdata = r_mem_data[r_rd_ptr];
    assign io_axis_str_to_trans_bits_tkeep = r_mem_keep[r_rd_ptr];
    assign io_axis_str_to_trans_bits_tlast = r_mem_last[r_rd_ptr];
    assign io_hdr_valid                    = r_hdr_valid;
    assign io_hdr_dst                      = r_hdr_dst;
    assign io_hdr_src                      = r_hdr_src;
    assign io_drop_cnt                     = r_drop_cnt;
    assign io_runt_cnt                     = r_runt_cnt;

endmodule

// File: tb/tb_rx_depacketing_hdr.sv
// Directed testbench for rx_depacketing_hdr (HDR_BEATS=1, CNT_W=2, local id 0x0005).
module tb_rx_depacketing_hdr;

    localparam int DATA_W = 128;
    localparam int KEEP_W = 4;
    localparam int CNT_W  = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [15:0]       local_id;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [KEEP_W-1:0] in_keep;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [KEEP_W-1:0] out_keep;
    logic              out_last;
    logic              hdr_valid;
    logic [15:0]       hdr_dst;
    logic [15:0]       hdr_src;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  runt_cnt;

    int n_total   = 0;
    int n_pass    = 0;
    int n_timeout = 0;

    // monitor state
    int           cyc         = 0;
    int           hdr_pulses  = 0;
    int           valid_cyc   = 0;
    int           acc_cnt     = 0;
    int           nr_cnt      = 0;
    int           stable_err  = 0;
    int           out_wr      = 0;
    logic [132:0] out_log [0:63];
    logic         prev_stall  = 1'b0;
    logic [132:0] prev_beat   = '0;

    int  rd;
    int  h0, o0, v0, nr0, a0, s0, c0;
    logic bp_done;

    rx_depacketing_hdr #(
        .DATA_W(DATA_W), .KEEP_W(KEEP_W), .HDR_BEATS(1), .PASS_ALL(1'b0), .CNT_W(CNT_W)
    ) dut (
        .clock                             (clock),
        .reset                             (reset),
        .io_local_id                       (local_id),
        .io_axi_str_from_router_valid      (in_valid),
        .io_axi_str_from_router_ready      (in_ready),
        .io_axi_str_from_router_bits_tdata (in_data),
        .io_axi_str_from_router_bits_tkeep (in_keep),
        .io_axi_str_from_router_bits_tlast (in_last),
        .io_axis_str_to_trans_valid        (out_valid),
        .io_axis_str_to_trans_ready        (out_ready),
        .io_axis_str_to_trans_bits_tdata   (out_data),
        .io_axis_str_to_trans_bits_tkeep   (out_keep),
        .io_axis_str_to_trans_bits_tlast   (out_last),
        .io_hdr_valid                      (hdr_valid),
        .io_hdr_dst                        (hdr_dst),
        .io_hdr_src                        (hdr_src),
        .io_drop_cnt                       (drop_cnt),
        .io_runt_cnt                       (runt_cnt)
    );

    always #5 clock = ~clock;

    // cycle counter
    always @(posedge clock) cyc <= cyc + 1;

    // observe handshakes and pulses mid-cycle
    always @(negedge clock) begin
        if (reset) begin
            if (hdr_valid)              hdr_pulses <= hdr_pulses + 1;
            if (out_valid)              valid_cyc  <= valid_cyc + 1;
            if (in_valid && in_ready)   acc_cnt    <= acc_cnt + 1;
            if (!in_ready)              nr_cnt     <= nr_cnt + 1;
            if (out_valid && out_ready) begin
                out_log[out_wr] <= {out_last, out_keep, out_data};
                out_wr          <= out_wr + 1;
            end
            if (prev_stall && out_valid && ({out_last, out_keep, out_data} !== prev_beat))
                stable_err <= stable_err + 1;
            prev_stall <= out_valid && !out_ready;
            prev_beat  <= {out_last, out_keep, out_data};
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] pay(input int f, input int i);
        return {32'(f), 32'hC0DE_0000, 32'(i), ~32'(i)};
    endfunction

    task automatic send_beat(input logic [127:0] d, input logic last);
        int w;
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = 4'hf;
        in_last  = last;
        w = 0;
        @(negedge clock);
        while (!in_ready && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) n_timeout++;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input int n_pay, input int f);
        send_beat({96'h0, hdr}, (n_pay == 0));
        for (int i = 1; i <= n_pay; i++) send_beat(pay(f, i), (i == n_pay));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input int f, input int i, input logic last);
        check({tag, "_data"}, out_log[rd][127:0], pay(f, i));
        check({tag, "_last"}, 128'(out_log[rd][132]), 128'(last));
        rd++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        local_id  = 16'h0005;
        in_valid  = 1'b0;
        in_data   = '0;
        in_keep   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        bp_done   = 1'b0;

        // reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready",  128'(in_ready),  128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_hdr_valid", 128'(hdr_valid), 128'(0));
        check("rst_hdr_dst",   128'(hdr_dst),   128'(0));
        check("rst_hdr_src",   128'(hdr_src),   128'(0));
        check("rst_drop",      128'(drop_cnt),  128'(0));
        check("rst_runt",      128'(runt_cnt),  128'(0));
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rdy_after_rst", 128'(in_ready), 128'(1));

        // matching 3-beat frame
        h0 = hdr_pulses; rd = out_wr; o0 = out_wr;
        send_beat({96'h0, 32'h0009_0005}, 1'b0);
        check("t1_hdr_pulse", 128'(hdr_valid), 128'(1));
        check("t1_hdr_dst",   128'(hdr_dst),   128'(16'h0005));
        check("t1_hdr_src",   128'(hdr_src),   128'(16'h0009));
        send_beat(pay(1, 1), 1'b0);
        check("t1_lat_valid", 128'(out_valid), 128'(1));
        check("t1_lat_data",  out_data,        pay(1, 1));
        check("t1_hdr_once",  128'(hdr_valid), 128'(0));
        send_beat(pay(1, 2), 1'b1);
        idle(3);
        check("t1_hdr_cnt", 128'(hdr_pulses - h0), 128'(1));
        check("t1_n_out",   128'(out_wr - o0),     128'(2));
        expect_out("t1_b1", 1, 1, 1'b0);
        expect_out("t1_b2", 1, 2, 1'b1);
        check("t1_drop", 128'(drop_cnt), 128'(0));

        // filtered frame, then a matching one
        h0 = hdr_pulses; v0 = valid_cyc; nr0 = nr_cnt;
        send_frame(32'h0009_0006, 2, 2);
        idle(3);
        check("t2_no_valid", 128'(valid_cyc - v0), 128'(0));
        check("t2_ready",    128'(nr_cnt - nr0),   128'(0));
        check("t2_drop",     128'(drop_cnt),       128'(1));
        check("t2_no_hdr",   128'(hdr_pulses - h0), 128'(0));
        h0 = hdr_pulses; rd = out_wr; o0 = out_wr;
        send_frame(32'h0009_0005, 2, 3);
        idle(3);
        check("t2_hdr_cnt", 128'(hdr_pulses - h0), 128'(1));
        check("t2_n_out",   128'(out_wr - o0),     128'(2));
        expect_out("t2_b1", 3, 1, 1'b0);
        expect_out("t2_b2", 3, 2, 1'b1);

        // runt: tlast on the header beat
        h0 = hdr_pulses; v0 = valid_cyc;
        send_beat({96'h0, 32'h0009_0005}, 1'b1);
        idle(3);
        check("t3_runt",     128'(runt_cnt),        128'(1));
        check("t3_no_hdr",   128'(hdr_pulses - h0), 128'(0));
        check("t3_no_valid", 128'(valid_cyc - v0),  128'(0));
        h0 = hdr_pulses; rd = out_wr; o0 = out_wr;
        send_frame(32'h000A_0005, 1, 4);
        idle(3);
        check("t3_hdr_cnt", 128'(hdr_pulses - h0), 128'(1));
        check("t3_hdr_src", 128'(hdr_src),         128'(16'h000A));
        check("t3_n_out",   128'(out_wr - o0),     128'(1));
        expect_out("t3_b1", 4, 1, 1'b1);

        // backpressure over a 6-payload-beat frame
        out_ready = 1'b0;
        a0 = acc_cnt; rd = out_wr; o0 = out_wr; s0 = stable_err;
        bp_done = 1'b0;
        fork
            begin
                send_frame(32'h0009_0005, 6, 5);
                bp_done = 1'b1;
            end
        join_none
        idle(10);
        check("t4_in_ready", 128'(in_ready),      128'(0));
        check("t4_accepted", 128'(acc_cnt - a0),  128'(3));
        check("t4_valid",    128'(out_valid),     128'(1));
        check("t4_head",     out_data,            pay(5, 1));
        out_ready = 1'b1;
        for (int k = 0; k < 100 && !bp_done; k++) idle(1);
        check("t4_done", 128'(bp_done), 128'(1));
        idle(4);
        check("t4_n_out",  128'(out_wr - o0),     128'(6));
        for (int i = 1; i <= 6; i++) expect_out("t4_b", 5, i, (i == 6));
        check("t4_stable", 128'(stable_err - s0), 128'(0));

        // three back-to-back 2-beat frames
        h0 = hdr_pulses; rd = out_wr; o0 = out_wr; nr0 = nr_cnt; c0 = cyc;
        for (int f = 6; f <= 8; f++) begin
            send_beat({96'h0, 32'h0009_0005}, 1'b0);
            send_beat(pay(f, 1), 1'b1);
        end
        check("t5_cycles",  128'(cyc - c0),    128'(6));
        check("t5_ready",   128'(nr_cnt - nr0), 128'(0));
        idle(3);
        check("t5_hdr_cnt", 128'(hdr_pulses - h0), 128'(3));
        check("t5_n_out",   128'(out_wr - o0),     128'(3));
        for (int f = 6; f <= 8; f++) expect_out("t5_b", f, 1, 1'b1);

        // asynchronous reset mid-payload
        out_ready = 1'b0;
        send_beat({96'h0, 32'h0009_0005}, 1'b0);
        send_beat(pay(9, 1), 1'b0);
        send_beat(pay(9, 2), 1'b0);
        check("t6_pre_valid", 128'(out_valid), 128'(1));
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 128'(out_valid), 128'(0));
        check("t6_rst_ready", 128'(in_ready),  128'(0));
        check("t6_rst_drop",  128'(drop_cnt),  128'(0));
        check("t6_rst_runt",  128'(runt_cnt),  128'(0));
        check("t6_rst_dst",   128'(hdr_dst),   128'(0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset     = 1'b1;
        out_ready = 1'b1;
        rd = out_wr; o0 = out_wr;
        send_frame(32'h000B_0005, 2, 10);
        idle(3);
        check("t6_hdr_src", 128'(hdr_src),     128'(16'h000B));
        check("t6_n_out",   128'(out_wr - o0), 128'(2));
        expect_out("t6_b1", 10, 1, 1'b0);
        expect_out("t6_b2", 10, 2, 1'b1);

        // drop counter saturation at 3 with CNT_W=2
        for (int i = 0; i < 5; i++) send_frame(32'h0009_0006, 1, 11);
        idle(2);
        check("t7_drop_sat", 128'(drop_cnt), 128'(3));

        check("timeouts", 128'(n_timeout), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
